wb_io_ctrl: RTL and testbench

WB_IO_CTRL -- requirements
Module: wb_io_ctrl

---
 rtl/wb_io_ctrl_if.sv | 41 ++++
 rtl/wb_io_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_wb_io_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_io_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_io_ctrl_if
// Description : Wishbone classic slave bus bundle for wb_io_ctrl.
//               slave  modport : cyc/stb/we/sel/adr/dat_i in, dat_o/ack out
//               master modport : mirror image, used by the bus master
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_io_ctrl_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_cyc_i,
        input  wbs_stb_i,
        input  wbs_we_i,
        input  wbs_sel_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_dat_o,
        output wbs_ack_o
    );

    modport master (
        output wbs_cyc_i,
        output wbs_stb_i,
        output wbs_we_i,
        output wbs_sel_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_dat_o,
        input  wbs_ack_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wb_io_ctrl
// Description : Wishbone-controlled IO pad block. Per pad: output value (OUT),
//               active-low output enable (OEB), synchronised input (IN) and,
//               optionally, rising-edge interrupt enable/status.
//               Register map (offset = adr[7:0], k=0/1 -> bits 32k..32k+31):
//                 0x00+4k OUT  RW | 0x10+4k OEB RW | 0x20+4k IN RO
//                 0x30+4k IRQ_EN RW | 0x40+4k IRQ_STAT W1C
// Ports       : wb_clk_i, wb_rst_i (async, active-high)
//               wbs        : Wishbone slave bundle (wb_io_ctrl_if.slave)
//               io_active  : pad enable; low parks all pads (out 0, oeb 1)
//               io_in      : asynchronous pad inputs
//               io_out     : pad output values
//               io_oeb     : pad output enables, active-low
//               irq        : registered level interrupt
// Config      : define WB_IO_CTRL_IRQ_EN to build the edge-interrupt logic;
//               without it IRQ_EN/IRQ_STAT read 0 and irq is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_io_ctrl #(
    parameter int          NUM_IO      = 38,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADR    = 32'h3000_0000
) (
    input  wire logic              wb_clk_i,
    input  wire logic              wb_rst_i,
    wb_io_ctrl_if.slave            wbs,
    input  wire logic              io_active,
    input  wire logic [NUM_IO-1:0] io_in,
    output logic      [NUM_IO-1:0] io_out,
    output logic      [NUM_IO-1:0] io_oeb,
    output logic                   irq
);

    localparam logic [3:0] c_REG_OUT  = 4'h0;
    localparam logic [3:0] c_REG_OEB  = 4'h1;
    localparam logic [3:0] c_REG_IN   = 4'h2;
`ifdef WB_IO_CTRL_IRQ_EN
    localparam logic [3:0] c_REG_IEN  = 4'h3;
    localparam logic [3:0] c_REG_ISTAT = 4'h4;
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              w_sel;
    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic [3:0]        w_reg_idx;
    logic              w_word;
    logic              w_slot_ok;
    logic [NUM_IO-1:0] w_wmask;
    logic [NUM_IO-1:0] w_wdata;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_sel     = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                       (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    // One access per ack: a held strobe is served every second cycle.
    assign w_acc     = w_sel & ~wbs.wbs_ack_o;
    assign w_wr      = w_acc &  wbs.wbs_we_i;
    assign w_rd      = w_acc & ~wbs.wbs_we_i;
    assign w_reg_idx = wbs.wbs_adr_i[7:4];
    assign w_word    = wbs.wbs_adr_i[2];
    // Offsets 0x8/0xC inside each 16-byte group are unmapped.
    assign w_slot_ok = ~wbs.wbs_adr_i[3];
    // Byte-address bits below the word are don't-care for this block.
    assign w_unused  = ^wbs.wbs_adr_i[1:0];

    // Per-pad write mask: pad i lives in word i/32, byte lane (i%32)/8.
    always_comb begin
        w_wmask = '0;
        w_wdata = '0;
        for (int i = 0; i < NUM_IO; i++) begin
            w_wdata[i] = wbs.wbs_dat_i[i % 32];
            w_wmask[i] = ((i >= 32) == w_word) && wbs.wbs_sel_i[(i % 32) / 8];
        end
    end

    // Zero-extend a pad vector to 64 bits and return the addressed word.
    function automatic logic [31:0] pick_word(input logic [NUM_IO-1:0] v,
                                              input logic              word);
        logic [63:0] ext;
        ext             = '0;
        ext[NUM_IO-1:0] = v;
        return word ? ext[63:32] : ext[31:0];
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic [NUM_IO-1:0] r_sync [SYNC_STAGES];
    logic [NUM_IO-1:0] w_in;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
            r_sync[0] <= io_in;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
    end

    assign w_in = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // OUT / OEB registers
    // ------------------------------------------------------------------
    logic [NUM_IO-1:0] r_out;
    logic [NUM_IO-1:0] r_oeb;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_out <= '0;
            r_oeb <= '1;
        end else begin
            if (w_wr && w_slot_ok && (w_reg_idx == c_REG_OUT))
                r_out <= (r_out & ~w_wmask) | (w_wdata & w_wmask);
            if (w_wr && w_slot_ok && (w_reg_idx == c_REG_OEB))
                r_oeb <= (r_oeb & ~w_wmask) | (w_wdata & w_wmask);
        end
    end

    // io_active gates the pads only; register contents are untouched.
    assign io_out = r_out & {NUM_IO{io_active}};
    assign io_oeb = r_oeb | {NUM_IO{~io_active}};

    // ------------------------------------------------------------------
    // Edge interrupt
    // ------------------------------------------------------------------
`ifdef WB_IO_CTRL_IRQ_EN
    localparam int              c_ARM_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [c_ARM_W-1:0] c_ARM_CNT = c_ARM_W'(SYNC_STAGES + 1);

    logic [NUM_IO-1:0]  r_irq_en;
    logic [NUM_IO-1:0]  r_irq_stat;
    logic [NUM_IO-1:0]  r_prev;
    logic [c_ARM_W-1:0] r_arm_cnt;
    logic               r_irq;
    logic               w_armed;
    logic [NUM_IO-1:0]  w_rise;
    logic [NUM_IO-1:0]  w_clr;

    // Edges are ignored until the synchroniser and edge history have been
    // refilled after reset, so a pad already high at release is not an edge.
    assign w_armed = (r_arm_cnt == c_ARM_CNT);
    assign w_rise  = w_in & ~r_prev & r_irq_en & {NUM_IO{w_armed}};
    assign w_clr   = (w_wr && w_slot_ok && (w_reg_idx == c_REG_ISTAT)) ?
                     (w_wdata & w_wmask) : '0;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_irq_en   <= '0;
            r_irq_stat <= '0;
            r_prev     <= '0;
            r_arm_cnt  <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_prev <= w_in;
            if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
            if (w_wr && w_slot_ok && (w_reg_idx == c_REG_IEN))
                r_irq_en <= (r_irq_en & ~w_wmask) | (w_wdata & w_wmask);
            // Set is OR-ed in after the clear so a coincident edge wins.
            r_irq_stat <= (r_irq_stat & ~w_clr) | w_rise;
            r_irq      <= |(r_irq_stat & r_irq_en);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_slot_ok) begin
            case (w_reg_idx)
                c_REG_OUT:   w_rdata = pick_word(r_out, w_word);
                c_REG_OEB:   w_rdata = pick_word(r_oeb, w_word);
                c_REG_IN:    w_rdata = pick_word(w_in, w_word);
`ifdef WB_IO_CTRL_IRQ_EN
                c_REG_IEN:   w_rdata = pick_word(r_irq_en, w_word);
                c_REG_ISTAT: w_rdata = pick_word(r_irq_stat, w_word);
`endif
                default:     w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs.wbs_ack_o <= 1'b0;
            wbs.wbs_dat_o <= '0;
        end else begin
            wbs.wbs_ack_o <= w_acc;
            // Read data only moves on a read ack; it holds otherwise.
            if (w_rd) wbs.wbs_dat_o <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_io_ctrl
// Description : Self-checking bench for wb_io_ctrl (NUM_IO=38, 2 sync stages).
//               Read expectations are queued when a read is issued and
//               compared when the acknowledge returns data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_io_ctrl;
    localparam int          NUM_IO = 38;
    localparam int          SS     = 2;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [63:0] c_ALL1 = {{(64-NUM_IO){1'b0}}, {NUM_IO{1'b1}}};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              io_active;
    logic [NUM_IO-1:0] io_in;
    logic [NUM_IO-1:0] io_out;
    logic [NUM_IO-1:0] io_oeb;
    logic              irq;

    always #5 clk = ~clk;

    wb_io_ctrl_if wbs ();

    wb_io_ctrl #(
        .NUM_IO      (NUM_IO),
        .SYNC_STAGES (SS),
        .BASE_ADR    (BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs       (wbs.slave),
        .io_active (io_active),
        .io_in     (io_in),
        .io_out    (io_out),
        .io_oeb    (io_oeb),
        .irq       (irq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // One Wishbone classic transfer; gives up after 8 cycles without ack.
    task automatic bus(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, output logic [31:0] rd, output bit acked);
        acked = 1'b0;
        rd    = '0;
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = we;
        wbs.wbs_sel_i = sel;
        wbs.wbs_adr_i = adr;
        wbs.wbs_dat_i = dat;
        for (int n = 0; n < 8 && !acked; n++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o) begin
                acked = 1'b1;
                rd    = wbs.wbs_dat_o;
            end
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [7:0] off, input logic [3:0] sel,
                      input logic [31:0] dat);
        logic [31:0] rd;
        bit          acked;
        bus(1'b1, BASE | 32'(off), sel, dat, rd, acked);
        check({tag, "_ack"}, 64'(acked), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_ackw"}, 64'(wbs.wbs_ack_o), 64'd0);
    endtask

    task automatic rdchk(input string tag, input logic [7:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        bit          acked;
        exp_t        e;
        sb.push_back('{tag, exp});
        bus(1'b0, BASE | 32'(off), 4'hF, 32'h0, rd, acked);
        check({tag, "_ack"}, 64'(acked), 64'd1);
        e = sb.pop_front();
        check(e.tag, 64'(rd), 64'(e.val));
        @(posedge clk);
        #1;
        check({tag, "_ackw"}, 64'(wbs.wbs_ack_o), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [1:0] pat;

        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_sel_i = 4'h0;
        wbs.wbs_adr_i = '0;
        wbs.wbs_dat_i = '0;
        io_active     = 1'b0;
        io_in         = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ack",  64'(wbs.wbs_ack_o), 64'd0);
        check("rst_dat",  64'(wbs.wbs_dat_o), 64'd0);
        check("rst_irq",  64'(irq), 64'd0);
        check("rst_out",  64'(io_out), 64'd0);
        check("rst_oeb",  64'(io_oeb), c_ALL1);
        rdchk("rst_oeb0", 8'h10, 32'hFFFF_FFFF);
        rdchk("rst_oeb1", 8'h14, 32'h0000_003F);
        rdchk("rst_out0", 8'h00, 32'h0);

        // Byte-lane write and pad output
        wr("out0_lo", 8'h00, 4'b0011, 32'hA5A5_A5A5);
        wr("oeb0_z",  8'h10, 4'hF, 32'h0);
        io_active = 1'b1;
        #1;
        check("pad_lo", 64'(io_out[15:0]), 64'h A5A5);
        check("pad_hi", 64'(io_out[31:16]), 64'h0);
        rdchk("out0_rb", 8'h00, 32'h0000_A5A5);

        // io_active gating
        wr("out0_ff", 8'h00, 4'hF, 32'hFFFF_FFFF);
        io_active = 1'b0;
        #1;
        check("park_out", 64'(io_out), 64'd0);
        check("park_oeb", 64'(io_oeb), c_ALL1);
        io_active = 1'b1;
        #1;
        check("act_out",  64'(io_out[31:0]), 64'h FFFF_FFFF);
        check("act_oeb",  64'(io_oeb[31:0]), 64'h0);
        check("act_oeb1", 64'(io_oeb[37:32]), 64'h3F);
        rdchk("out0_kept", 8'h00, 32'hFFFF_FFFF);

        // Upper word truncation, unmapped offset, foreign block
        wr("out1_ff", 8'h04, 4'hF, 32'hFFFF_FFFF);
        rdchk("out1_rb", 8'h04, 32'h0000_003F);
        check("pad_out1", 64'(io_out[37:32]), 64'h3F);
        wr("unm_wr", 8'h08, 4'hF, 32'hFFFF_FFFF);
        rdchk("unm_08", 8'h08, 32'h0);
        rdchk("unm_80", 8'h80, 32'h0);
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b0;
        wbs.wbs_adr_i = 32'h3000_0100;
        acks = 0;
        for (int n = 0; n < 10; n++) begin
            @(posedge clk);
            #1;
            if (wbs.wbs_ack_o) acks++;
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        check("noack_cnt", 64'(acks), 64'd0);

        // Held strobe: ack every second cycle
        @(negedge clk);
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_adr_i = BASE;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            pat = 2'(n % 2);
            check($sformatf("b2b_ack%0d", n), 64'(wbs.wbs_ack_o), 64'(pat == 2'd0));
        end
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        @(posedge clk);

        // Synchroniser latency: a read acked at the second edge still sees old data
        @(negedge clk);
        io_in = 38'h2A_DEAD_BEEF;
        rdchk("in0_old", 8'h20, 32'h0);
        rdchk("in0_new", 8'h20, 32'hDEAD_BEEF);
        rdchk("in1_new", 8'h24, 32'h0000_002A);

`ifdef WB_IO_CTRL_IRQ_EN
        @(negedge clk);
        io_in = '0;
        repeat (4) @(posedge clk);
        wr("ien0", 8'h30, 4'hF, 32'h1);
        @(negedge clk);
        io_in[1:0] = 2'b11;
        repeat (SS + 1) @(posedge clk);
        #1;
        check("irq_pre", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        check("irq_set", 64'(irq), 64'd1);
        rdchk("istat_1", 8'h40, 32'h1);
        wr("w1c", 8'h40, 4'hF, 32'h1);
        check("irq_clr", 64'(irq), 64'd0);
        rdchk("istat_0", 8'h40, 32'h0);
        @(negedge clk);
        io_in[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        io_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr("w1c_race", 8'h40, 4'hF, 32'h1);
        rdchk("istat_race", 8'h40, 32'h1);
        check("irq_race", 64'(irq), 64'd1);
        wr("ien0_off", 8'h30, 4'hF, 32'h0);
        check("irq_mask", 64'(irq), 64'd0);
        rdchk("istat_mask", 8'h40, 32'h1);
`else
        @(negedge clk);
        io_in = '0;
        repeat (4) @(posedge clk);
        wr("ien0", 8'h30, 4'hF, 32'h1);
        @(negedge clk);
        io_in[0] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("irq_off", 64'(irq), 64'd0);
        rdchk("ien0_rd", 8'h30, 32'h0);
        rdchk("istat_off", 8'h40, 32'h0);
`endif

        // Reset in the strobe cycle of a write
        @(negedge clk);
        io_in = '1;
        wbs.wbs_cyc_i = 1'b1;
        wbs.wbs_stb_i = 1'b1;
        wbs.wbs_we_i  = 1'b1;
        wbs.wbs_sel_i = 4'hF;
        wbs.wbs_adr_i = BASE | 32'h10;
        wbs.wbs_dat_i = 32'h0000_0000;
        #2;
        rst = 1'b1;
        #1;
        check("arst_ack", 64'(wbs.wbs_ack_o), 64'd0);
        check("arst_dat", 64'(wbs.wbs_dat_o), 64'd0);
        check("arst_out", 64'(io_out), 64'd0);
        check("arst_oeb", 64'(io_oeb), c_ALL1);
        check("arst_irq", 64'(irq), 64'd0);
        @(posedge clk);
        #1;
        check("arst_ack2", 64'(wbs.wbs_ack_o), 64'd0);
        wbs.wbs_cyc_i = 1'b0;
        wbs.wbs_stb_i = 1'b0;
        wbs.wbs_we_i  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`ifdef WB_IO_CTRL_IRQ_EN
        // Pad already high at release must not be seen as an edge.
        wr("ien0_rel", 8'h30, 4'hF, 32'h1);
        repeat (4) @(posedge clk);
        rdchk("istat_rel", 8'h40, 32'h0);
`endif
        rdchk("oeb0_unch", 8'h10, 32'hFFFF_FFFF);
        rdchk("out0_rst", 8'h00, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
